out_arbiter: RTL and testbench
==============================

# out_arbiter

Round-robin controller that shares the single-bit `out` line among NREQ requesters. Each requester asks with `req` and is granted exclusive use of `out` for a bounded burst. While granted, its serial data bit `din[i]` is routed to `out`. Sits between the requesting sub-blocks and the top-level `out` pin, and sequences all traffic on it.

## Interface
- `NREQ`, 4: number of requesters; legal range 2..8.
- `MAX_BURST`, 8: maximum consecutive grant cycles per burst; legal range 2..256.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-low (`rst`=0 at a rising edge resets).
- `req`  in  NREQ  request per requester; level-sensitive, held high while access is wanted.
- `din`  in  NREQ  serial data bit per requester; only the granted bit is used.
- `grant`  out  NREQ  registered grant; one-hot or all-zero.
- `out`  out  1  shared output: `|(grant & din)`, combinational from registered `grant`.
- `busy`  out  1  registered; high when the state is not IDLE.

## Operation
- States:
  - IDLE: `grant`=0; arbitrate.
  - GRANT: one-hot `grant`; burst counter runs.
  - GAP: `grant`=0 for exactly one cycle; arbitrate.
- Internal registers:
  - `ptr`: priority pointer, width clog2(NREQ).
  - `cnt`: burst counter, width clog2(MAX_BURST).
- Arbitration (in IDLE and GAP):
  - Scan `req` from index `ptr` upward, wrapping modulo NREQ.
  - The first set bit `g` wins.
  - At the edge: `grant`<=onehot(g), `cnt`<=0, state<=GRANT.
  - If `req`=0: IDLE stays IDLE; GAP goes to IDLE.
- In GRANT, at each edge, release when either condition holds:
  - `req[g]`=0 (requester dropped), or
  - `cnt`=MAX_BURST-1 (burst exhausted).
- Release action:
  - `grant`<=0, state<=GAP.
  - `ptr`<=(g+1) mod NREQ.
  - Requests from other indices during GRANT are ignored until release.
- No release: `cnt`<=`cnt`+1; `grant` is unchanged.
- `ptr` changes only on release. A single continuous requester therefore receives repeated bursts separated by one GAP cycle.
- `out`:
  - Is 0 whenever `grant`=0.
  - Otherwise equals `din[g]` in the same cycle, with no register.
  - `din` of non-granted requesters has no effect.
- Reset (`rst`=0 at an edge), from any state:
  - state<=IDLE, `grant`<=0, `busy`<=0, `cnt`<=0, `ptr`<=0.
  - `out` is therefore 0 from the cycle after that edge.
  - `req` is ignored during reset.
  - A reset mid-burst drops `grant` immediately after that edge.
  - After reset, `ptr`=0, so requester 0 has priority.

## Timing
- Grant latency: `req[i]` sampled high at edge k in IDLE or GAP (and winning) gives `grant[i]`=1 from edge k.
- Burst length with `req` held: exactly MAX_BURST cycles of `grant`, then 1 GAP cycle.
- Early release: `req[g]` sampled low at edge m gives `grant` low from edge m.
  - So `grant` stays high for as many cycles as `req` was sampled high, lagging by one cycle.
- Minimum spacing between any two grants: 1 cycle with `grant`=0.
- `busy`: 1 in GRANT and GAP; 0 in IDLE.
- Simultaneous release by `req` drop and `cnt` limit: treated as one release, with identical behaviour.
- `req[g]` rising again in GAP: it competes normally. With `ptr`=g+1, it loses to any other active requester.

## Test plan
- Reset:
  - `rst`=0 for 3 cycles with `req`=4'b1111 → `grant`=0, `out`=0, `busy`=0 throughout.
  - First edge with `rst`=1 → `grant`=4'b0001, `busy`=1.
- Single continuous requester: `req`=4'b0100 for 30 cycles, MAX_BURST=8.
  - `grant`=4'b0100 for 8 cycles, then 0 for 1 cycle, repeating.
  - `busy` stays 1.
- All requesting: `req`=4'b1111 held.
  - Grant order 0001, 0010, 0100, 1000, 0001, ….
  - Each grant lasts 8 cycles, with a 1-cycle gap between grants.
- Early release: `req[1]` high for 3 cycles, then low.
  - `grant`=4'b0010 for exactly 3 cycles, lagging `req` by 1.
  - Then 1 GAP cycle with `busy`=1, then IDLE with `busy`=0.
- Data routing: `grant`=4'b0100; toggle `din[2]` 1,0,1,1 and randomise the other `din` bits.
  - `out` shows 1,0,1,1 in the same cycles.
  - With `grant`=0, `out`=0 for any `din`.
- Reset mid-burst: assert `rst`=0 at cycle 4 of a burst to requester 3.
  - `grant`=0 from that edge.
  - After release, with `req`=4'b1010, the first grant is 4'b0010 (`ptr` reset to 0).

Source files
------------

// File: rtl/out_arbiter.sv
// rtl/out_arbiter.sv - round-robin burst arbiter sharing one serial output line
//
// Purpose: grants exclusive use of the single-bit out line to one of NREQ
// requesters at a time, for at most MAX_BURST cycles per burst, with one idle
// GAP cycle between any two grants. Priority rotates to the requester after
// the one most recently released.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-low reset
//   req    in   [NREQ] level-sensitive request per requester
//   din    in   [NREQ] serial data bit per requester
//   grant  out  [NREQ] registered one-hot (or zero) grant
//   out    out  shared line, |(grant & din), combinational
//   busy   out  registered, high while granting or in the GAP cycle
module out_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] din,
  output logic [NREQ-1:0] grant,
  output logic            out,
  output logic            busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [CW-1:0] cnt;

  logic          win_found;
  logic [PW-1:0] win_idx;
  logic          release_now;

  // Rotating priority scan: first active request at or above ptr, wrapping.
  always_comb begin
    int            j;
    logic [PW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      cand = PW'(j);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // A dropped request and an exhausted burst release identically.
  assign release_now = (state == S_GRANT) && (!req[gidx] || (cnt == LAST_CNT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      grant <= '0;
      busy  <= 1'b0;
      cnt   <= '0;
      ptr   <= '0;
      gidx  <= '0;
    end else begin
      case (state)
        S_IDLE, S_GAP: begin
          if (win_found) begin
            grant          <= '0;
            grant[win_idx] <= 1'b1;
            gidx           <= win_idx;
            cnt            <= '0;
            state          <= S_GRANT;
            busy           <= 1'b1;
          end else begin
            grant <= '0;
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_GRANT: begin
          if (release_now) begin
            grant <= '0;
            state <= S_GAP;
            busy  <= 1'b1;
            ptr   <= (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          grant <= '0;
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out = |(grant & din);

endmodule

// File: tb/tb_out_arbiter.sv
// tb/tb_out_arbiter.sv - self-checking bench for out_arbiter
module tb_out_arbiter;

  localparam int N  = 4;
  localparam int MB = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] din;
  logic [N-1:0] grant;
  logic         out;
  logic         busy;

  int total;
  int bad;

  // Reference model: who owns the line, how long it has had it, whose turn it is.
  int m_owner;
  int m_run;
  int m_ptr;
  bit m_gap;

  out_arbiter #(.NREQ(N), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .din   (din),
    .grant (grant),
    .out   (out),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic exp_busy();
    return (m_owner >= 0) || m_gap;
  endfunction

  function automatic logic exp_out();
    if (m_owner < 0) return 1'b0;
    return din[m_owner];
  endfunction

  function automatic int grant_index(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Apply inputs away from the edge, advance one clock, advance the model.
  task automatic tick(input logic r, input logic [N-1:0] q, input logic [N-1:0] d);
    @(negedge clk);
    rst = r;
    req = q;
    din = d;
    @(posedge clk);
    if (!r) begin
      m_owner = -1; m_run = 0; m_ptr = 0; m_gap = 0;
    end else if (m_owner >= 0) begin
      if (!q[m_owner] || m_run == MB - 1) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_run++;
      end
    end else begin
      m_gap = 0;
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && q[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_run   = 0;
        end
      end
    end
    #1;
  endtask

  task automatic go_idle();
    tick(1'b1, '0, N'($urandom));
    tick(1'b1, '0, N'($urandom));
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 4'b1111, N'($urandom));
      total++;
      if (grant !== 4'b0000 || out !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold c=%0d: grant=%b out=%b busy=%b want 0000/0/0", c, grant, out, busy);
      end
    end
    tick(1'b1, 4'b1111, N'($urandom));
    total++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_grant: grant=%b busy=%b want 0001/1", grant, busy);
    end
    total++;
    if (out !== exp_out()) begin
      bad++;
      $display("FAIL reset_first_out: out=%b want %b", out, exp_out());
    end
  endtask

  task automatic test_single();
    int run;
    go_idle();
    run = 0;
    for (int c = 0; c < 30; c++) begin
      tick(1'b1, 4'b0100, N'($urandom));
      total++;
      if (grant !== exp_grant() || busy !== 1'b1 || out !== exp_out()) begin
        bad++;
        $display("FAIL single c=%0d: grant=%b busy=%b out=%b want %b/1/%b", c, grant, busy, out, exp_grant(), exp_out());
      end
      if (grant == 4'b0100) begin
        run++;
      end else begin
        total++;
        if (run !== MB || grant !== 4'b0000) begin
          bad++;
          $display("FAIL single_burst_len: got %0d cycles grant=%b want %0d then 0000", run, grant, MB);
        end
        run = 0;
      end
    end
  endtask

  task automatic test_all();
    int run;
    int last;
    int idx;
    go_idle();
    run  = 0;
    last = -1;
    for (int c = 0; c < 45; c++) begin
      tick(1'b1, 4'b1111, N'($urandom));
      total++;
      if (grant !== exp_grant() || busy !== exp_busy() || out !== exp_out()) begin
        bad++;
        $display("FAIL all c=%0d: grant=%b busy=%b out=%b want %b/%b/%b", c, grant, busy, out, exp_grant(), exp_busy(), exp_out());
      end
      idx = grant_index(grant);
      if (idx >= 0 && run == 0 && last >= 0) begin
        total++;
        if (idx !== (last + 1) % N) begin
          bad++;
          $display("FAIL all_order: got %0d want %0d", idx, (last + 1) % N);
        end
      end
      if (idx >= 0) begin
        run++;
        last = idx;
      end else if (run > 0) begin
        total++;
        if (run !== MB) begin
          bad++;
          $display("FAIL all_burst_len: got %0d want %0d", run, MB);
        end
        run = 0;
      end
    end
  endtask

  task automatic test_early_release();
    logic [N-1:0] pat [0:5];
    logic         bexp [0:5];
    int           run;
    go_idle();
    pat[0] = 4'b0010; pat[1] = 4'b0010; pat[2] = 4'b0010;
    pat[3] = 4'b0000; pat[4] = 4'b0000; pat[5] = 4'b0000;
    bexp[0] = 1; bexp[1] = 1; bexp[2] = 1; bexp[3] = 1; bexp[4] = 0; bexp[5] = 0;
    run = 0;
    for (int c = 0; c < 6; c++) begin
      tick(1'b1, pat[c], N'($urandom));
      if (grant == 4'b0010) run++;
      total++;
      if (grant !== exp_grant() || busy !== bexp[c] || busy !== exp_busy()) begin
        bad++;
        $display("FAIL early c=%0d: grant=%b busy=%b want %b/%b", c, grant, busy, exp_grant(), bexp[c]);
      end
    end
    total++;
    if (run !== 3) begin
      bad++;
      $display("FAIL early_len: got %0d want 3", run);
    end
  endtask

  task automatic test_routing();
    logic bits [0:3];
    logic [N-1:0] d;
    go_idle();
    bits[0] = 1; bits[1] = 0; bits[2] = 1; bits[3] = 1;
    tick(1'b1, 4'b0100, N'($urandom));
    total++;
    if (grant !== 4'b0100) begin
      bad++;
      $display("FAIL route_grant: grant=%b want 0100", grant);
    end
    for (int c = 0; c < 4; c++) begin
      d    = N'($urandom);
      d[2] = bits[c];
      tick(1'b1, 4'b0100, d);
      total++;
      if (out !== bits[c]) begin
        bad++;
        $display("FAIL route_out c=%0d: out=%b want %b", c, out, bits[c]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, 4'b0000, N'($urandom));
      total++;
      if (grant !== 4'b0000 || out !== 1'b0) begin
        bad++;
        $display("FAIL route_idle c=%0d: grant=%b out=%b want 0000/0", c, grant, out);
      end
    end
  endtask

  task automatic test_reset_mid();
    go_idle();
    for (int c = 0; c < 3; c++) tick(1'b1, 4'b1000, N'($urandom));
    total++;
    if (grant !== 4'b1000) begin
      bad++;
      $display("FAIL mid_pre: grant=%b want 1000", grant);
    end
    tick(1'b0, 4'b1000, 4'b1111);
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0 || out !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: grant=%b busy=%b out=%b want 0000/0/0", grant, busy, out);
    end
    tick(1'b0, 4'b1010, 4'b1111);
    tick(1'b1, 4'b1010, N'($urandom));
    total++;
    if (grant !== 4'b0010) begin
      bad++;
      $display("FAIL mid_ptr: grant=%b want 0010", grant);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] q;
    logic         r;
    q = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) q = N'($urandom);
      r = ($urandom_range(0, 59) != 0);
      tick(r, q, N'($urandom));
      total++;
      if (grant !== exp_grant() || busy !== exp_busy() || out !== exp_out()) begin
        bad++;
        $display("FAIL random c=%0d: grant=%b busy=%b out=%b want %b/%b/%b", c, grant, busy, out, exp_grant(), exp_busy(), exp_out());
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    m_owner = -1; m_run = 0; m_ptr = 0; m_gap = 0;
    rst = 1'b0; req = '0; din = '0;
    test_reset();
    test_single();
    test_all();
    test_early_release();
    test_routing();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
